// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer
//   Write-side packet framer sitting directly upstream of the async FIFO, in
//   the W_CLK domain. It takes bytes from a VALID/READY source and pushes
//   exactly PKT_LEN payload bytes per packet into the FIFO. When CSUM_EN is
//   set, it appends one byte holding the XOR of the payload. FULL stalls both
//   the source and the FIFO write. PKT_DONE pulses once per completed packet,
//   and PKT_COUNT keeps a running count of completed packets.
//
// Ports
//   W_CLK      in   write-domain clock, rising edge
//   W_RST      in   synchronous reset, active-low
//   START      in   request one packet (sampled only when idle)
//   SRC_DATA   in   payload byte from the source
//   SRC_VALID  in   SRC_DATA is valid
//   SRC_READY  out  byte is accepted this cycle
//   FULL       in   FIFO full flag
//   W_INC      out  FIFO write strobe
//   WR_DATA    out  FIFO write data
//   BUSY       out  packet in progress
//   PKT_DONE   out  one-cycle pulse after the last byte of a packet is written
//   PKT_COUNT  out  completed packets since reset (wraps)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for START; no source or FIFO traffic
// DATA  | passing payload bytes source -> FIFO, counting them
// CSUM  | writing the accumulated XOR byte once FULL allows it

module fifo_pkt_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 10,
  parameter int LEN_WIDTH  = 4,
  parameter int CSUM_EN    = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] SRC_DATA,
  input  logic                  SRC_VALID,
  output logic                  SRC_READY,
  input  logic                  FULL,
  output logic                  W_INC,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  BUSY,
  output logic                  PKT_DONE,
  output logic [CNT_WIDTH-1:0]  PKT_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CSUM = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(PKT_LEN - 1);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic payload_wr;
  logic csum_wr;
  logic last_byte;

  // Source transfer and FIFO write happen on the same edge (zero latency).
  assign payload_wr = (state_q == S_DATA) & SRC_VALID & ~FULL;
  assign csum_wr    = (state_q == S_CSUM) & ~FULL;
  assign last_byte  = (byte_cnt_q == LAST_IDX);

  assign SRC_READY = (state_q == S_DATA) & ~FULL;
  assign W_INC     = payload_wr | csum_wr;
  assign WR_DATA   = (state_q == S_CSUM) ? csum_q : SRC_DATA;
  assign BUSY      = (state_q != S_IDLE);
  assign PKT_DONE  = done_q;
  assign PKT_COUNT = count_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    done_d     = 1'b0;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_DATA;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end

      S_DATA: begin
        if (payload_wr) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          csum_d     = csum_q ^ SRC_DATA;
          if (last_byte) begin
            if (CSUM_EN != 0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
        end
      end

      S_CSUM: begin
        if (csum_wr) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          count_d = count_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge W_CLK) begin
    if (!W_RST) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

endmodule
